// File: rtl/neck_pkg.sv
// Shared constants and saturation helper for the neck detection path.
package neck_pkg;

    localparam int OUT_W       = 13;
    localparam int SAT_IN_W    = 16;
    localparam int SAT_MAX     = 4095;
    localparam int SAT_MIN     = -4096;
    localparam int WARM_BLOCKS = 4;

    // Clamp a wide signed difference into the signed OUT_W output range.
    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [SAT_IN_W-1:0] v);
        logic signed [OUT_W-1:0] r;
        if (int'(v) > SAT_MAX) begin
            r = OUT_W'(SAT_MAX);
        end else if (int'(v) < SAT_MIN) begin
            r = OUT_W'(SAT_MIN);
        end else begin
            r = v[OUT_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/neck_block_avg.sv
// Block averager: sums 2^AVG_LOG2 valid samples and emits their truncated mean.
module neck_block_avg
    import neck_pkg::*;
#(
    parameter int unsigned DATA_W   = 12,
    parameter int unsigned AVG_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic [DATA_W-1:0] avg,
    output logic              avg_strobe
);

    localparam int unsigned ACC_W = DATA_W + AVG_LOG2;
    // A one-bit counter is kept even when every sample is its own block.
    localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic [CNT_W-1:0] cnt;

    assign acc_sum = acc + ACC_W'(sample_data);

    // Accumulate valid samples; on the last sample of a block publish the mean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            cnt        <= '0;
            avg        <= '0;
            avg_strobe <= 1'b0;
        end else if (clear) begin
            acc        <= '0;
            cnt        <= '0;
            avg        <= '0;
            avg_strobe <= 1'b0;
        end else begin
            avg_strobe <= 1'b0;
            if (sample_valid) begin
                if (cnt == CNT_LAST) begin
                    avg        <= DATA_W'(acc_sum >> AVG_LOG2);
                    avg_strobe <= 1'b1;
                    acc        <= '0;
                    cnt        <= '0;
                end else begin
                    acc <= acc_sum;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/neck_diff_calc.sv
// Neck-judge feeder: block-averages ADC samples and produces saturated
// first/second/third-order differences with a warm-up gated judge strobe.
module neck_diff_calc #(
    parameter int unsigned DATA_W   = 12,
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned OUT_W    = 13
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    sample_valid,
    input  logic [DATA_W-1:0]       sample_data,
    output logic signed [OUT_W-1:0] first_order_data,
    output logic signed [OUT_W-1:0] second_order_data,
    output logic signed [OUT_W-1:0] third_order_data,
    output logic                    en_judge
);

    import neck_pkg::SAT_IN_W;
    import neck_pkg::WARM_BLOCKS;
    import neck_pkg::sat_out;

    localparam int unsigned D1_W = DATA_W + 1;
    localparam int unsigned D2_W = DATA_W + 2;

    logic [DATA_W-1:0]             avg;
    logic                          avg_strobe;
    logic [DATA_W-1:0]             h1;
    logic signed [D1_W-1:0]        d1_prev;
    logic signed [D2_W-1:0]        d2_prev;
    logic [2:0]                    warm;
    logic signed [SAT_IN_W-1:0]    d1;
    logic signed [SAT_IN_W-1:0]    d2;
    logic signed [SAT_IN_W-1:0]    d3;

    neck_block_avg #(
        .DATA_W   (DATA_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_block_avg (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .avg          (avg),
        .avg_strobe   (avg_strobe)
    );

    // Exact successive differences against the unsaturated history.
    always_comb begin
        d1 = SAT_IN_W'(avg) - SAT_IN_W'(h1);
        d2 = d1 - SAT_IN_W'(d1_prev);
        d3 = d2 - SAT_IN_W'(d2_prev);
    end

    // Register saturated outputs and history on each new average; gate the strobe by warm-up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1                <= '0;
            d1_prev           <= '0;
            d2_prev           <= '0;
            warm              <= '0;
            first_order_data  <= '0;
            second_order_data <= '0;
            third_order_data  <= '0;
            en_judge          <= 1'b0;
        end else if (clear) begin
            h1                <= '0;
            d1_prev           <= '0;
            d2_prev           <= '0;
            warm              <= '0;
            first_order_data  <= '0;
            second_order_data <= '0;
            third_order_data  <= '0;
            en_judge          <= 1'b0;
        end else begin
            en_judge <= 1'b0;
            if (avg_strobe) begin
                first_order_data  <= sat_out(d1);
                second_order_data <= sat_out(d2);
                third_order_data  <= sat_out(d3);
                h1                <= avg;
                d1_prev           <= d1[D1_W-1:0];
                d2_prev           <= d2[D2_W-1:0];
                if (warm < 3'(WARM_BLOCKS)) begin
                    warm <= warm + 3'd1;
                end
                en_judge <= (warm >= 3'(WARM_BLOCKS - 1));
            end
        end
    end

endmodule

// File: tb/tb_neck_diff_calc.sv
// Self-checking bench for neck_diff_calc with a behavioural averages-history model.
module tb_neck_diff_calc;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear = 1'b0;
    logic              sample_valid = 1'b0;
    logic [11:0]       sample_data = '0;
    logic signed [12:0] first_order_data;
    logic signed [12:0] second_order_data;
    logic signed [12:0] third_order_data;
    logic              en_judge;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: block sum, completed averages, pending average.
    int m_cnt, m_sum, n_avg, pend_avg;
    bit pend;
    int hist[4];
    int e_d1, e_d2, e_d3;
    bit e_en;
    logic [39:0] m_exp;

    neck_diff_calc #(
        .DATA_W   (12),
        .AVG_LOG2 (2),
        .OUT_W    (13)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .clear             (clear),
        .sample_valid      (sample_valid),
        .sample_data       (sample_data),
        .first_order_data  (first_order_data),
        .second_order_data (second_order_data),
        .third_order_data  (third_order_data),
        .en_judge          (en_judge)
    );

    always #5 clk = ~clk;

    function automatic int clamp(input int v);
        if (v > 4095) return 4095;
        if (v < -4096) return -4096;
        return v;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_sum = 0; n_avg = 0; pend = 0; pend_avg = 0;
        for (int i = 0; i < 4; i++) hist[i] = 0;
        e_d1 = 0; e_d2 = 0; e_d3 = 0; e_en = 0;
        m_exp = '0;
    endtask

    // One clock edge of the reference: differences are taken straight from the
    // averages sequence, with averages before a restart treated as zero.
    task automatic model_edge(input bit v, input int d, input bit c);
        int x;
        if (c) begin
            model_reset();
            return;
        end
        e_en = 0;
        if (pend) begin
            x = pend_avg;
            e_d1 = clamp(x - hist[0]);
            e_d2 = clamp(x - 2 * hist[0] + hist[1]);
            e_d3 = clamp(x - 3 * hist[0] + 3 * hist[1] - hist[2]);
            hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = x;
            n_avg++;
            e_en = (n_avg >= 4);
            pend = 0;
        end
        if (v) begin
            m_sum += d;
            m_cnt++;
            if (m_cnt == N) begin
                pend = 1;
                pend_avg = m_sum / N;
                m_sum = 0;
                m_cnt = 0;
            end
        end
        m_exp = {e_en, 13'(e_d1), 13'(e_d2), 13'(e_d3)};
    endtask

    task automatic step(input bit v, input int d, input bit c);
        sample_valid = v;
        sample_data  = 12'(d);
        clear        = c;
        @(posedge clk);
        #1;
        model_edge(v, d, c);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        if ({en_judge, first_order_data, second_order_data, third_order_data} !== 40'd0) begin
            miscompares++;
            $display("FAIL reset got en=%b d=%0d/%0d/%0d exp en=0 d=0/0/0",
                     en_judge, first_order_data, second_order_data, third_order_data);
        end
        vectors++;
        #3 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_constant();
        int pulses = 0;
        step(0, 0, 1);
        for (int i = 0; i < 22; i++) begin
            step(i < 20, 2000, 0);
            if ({en_judge, first_order_data, second_order_data, third_order_data} !== m_exp) begin
                miscompares++;
                $display("FAIL constant cyc=%0d got en=%b d=%0d/%0d/%0d exp en=%b d=%0d/%0d/%0d", i,
                         en_judge, first_order_data, second_order_data, third_order_data, e_en, e_d1, e_d2, e_d3);
            end
            vectors++;
            if (en_judge) pulses++;
        end
        if (pulses != 2) begin
            miscompares++;
            $display("FAIL constant_pulses got %0d exp 2", pulses);
        end
        vectors++;
    endtask

    task automatic test_ramp();
        int s[4];
        int idx = 0;
        step(0, 0, 1);
        for (int b = 0; b < 5; b++) begin
            int av = 100 + 10 * b;
            s[0] = av - 20 + $urandom_range(0, 40);
            s[1] = av - 20 + $urandom_range(0, 40);
            s[2] = av - 20 + $urandom_range(0, 40);
            s[3] = 4 * av - s[0] - s[1] - s[2];
            for (int k = 0; k < 6; k++) begin
                step(k < 4, (k < 4) ? s[k] : 0, 0);
                if ({en_judge, first_order_data, second_order_data, third_order_data} !== m_exp) begin
                    miscompares++;
                    $display("FAIL ramp blk=%0d got en=%b d=%0d/%0d/%0d exp en=%b d=%0d/%0d/%0d", b,
                             en_judge, first_order_data, second_order_data, third_order_data, e_en, e_d1, e_d2, e_d3);
                end
                vectors++;
                if (en_judge) begin
                    if (int'(first_order_data) != 10 || int'(second_order_data) != 0 ||
                        int'(third_order_data) != 0) begin
                        miscompares++;
                        $display("FAIL ramp_strobe%0d got d=%0d/%0d/%0d exp d=10/0/0", idx,
                                 first_order_data, second_order_data, third_order_data);
                    end
                    vectors++;
                    idx++;
                end
            end
        end
    endtask

    task automatic test_step();
        int st_d1[3];
        int st_d2[3];
        int st_d3[3];
        int idx = 0;
        int lvl;
        st_d1[0] = 4095; st_d1[1] = 0;     st_d1[2] = 0;
        st_d2[0] = 4095; st_d2[1] = -4095; st_d2[2] = 0;
        st_d3[0] = 4095; st_d3[1] = -4096; st_d3[2] = 4095;
        step(0, 0, 1);
        for (int b = 0; b < 7; b++) begin
            lvl = (b < 4) ? 0 : 4095;
            for (int k = 0; k < 6; k++) begin
                step(k < 4, lvl, 0);
                if ({en_judge, first_order_data, second_order_data, third_order_data} !== m_exp) begin
                    miscompares++;
                    $display("FAIL step blk=%0d got en=%b d=%0d/%0d/%0d exp en=%b d=%0d/%0d/%0d", b,
                             en_judge, first_order_data, second_order_data, third_order_data, e_en, e_d1, e_d2, e_d3);
                end
                vectors++;
                if (en_judge) begin
                    if (idx >= 1 && idx <= 3) begin
                        if (int'(first_order_data) != st_d1[idx-1] || int'(second_order_data) != st_d2[idx-1] ||
                            int'(third_order_data) != st_d3[idx-1]) begin
                            miscompares++;
                            $display("FAIL step_strobe%0d got d=%0d/%0d/%0d exp d=%0d/%0d/%0d", idx,
                                     first_order_data, second_order_data, third_order_data,
                                     st_d1[idx-1], st_d2[idx-1], st_d3[idx-1]);
                        end
                        vectors++;
                    end
                    idx++;
                end
            end
        end
    endtask

    task automatic test_gapped();
        step(0, 0, 1);
        for (int i = 0; i < 78; i++) begin
            step((i % 3) == 0 && i < 72, 500, 0);
            if ({en_judge, first_order_data, second_order_data, third_order_data} !== m_exp) begin
                miscompares++;
                $display("FAIL gapped cyc=%0d got en=%b d=%0d/%0d/%0d exp en=%b d=%0d/%0d/%0d", i,
                         en_judge, first_order_data, second_order_data, third_order_data, e_en, e_d1, e_d2, e_d3);
            end
            vectors++;
        end
    endtask

    task automatic test_clear_mid();
        int pulses = 0;
        step(0, 0, 1);
        for (int i = 0; i < 22; i++) begin
            step(1, $urandom_range(0, 4095), 0);
            if ({en_judge, first_order_data, second_order_data, third_order_data} !== m_exp) begin
                miscompares++;
                $display("FAIL clear_pre cyc=%0d got en=%b d=%0d/%0d/%0d exp en=%b d=%0d/%0d/%0d", i,
                         en_judge, first_order_data, second_order_data, third_order_data, e_en, e_d1, e_d2, e_d3);
            end
            vectors++;
        end
        step(1, $urandom_range(0, 4095), 1);
        if ({en_judge, first_order_data, second_order_data, third_order_data} !== 40'd0) begin
            miscompares++;
            $display("FAIL clear_zero got en=%b d=%0d/%0d/%0d exp en=0 d=0/0/0",
                     en_judge, first_order_data, second_order_data, third_order_data);
        end
        vectors++;
        for (int i = 0; i < 18; i++) begin
            step(i < 16, $urandom_range(0, 4095), 0);
            if ({en_judge, first_order_data, second_order_data, third_order_data} !== m_exp) begin
                miscompares++;
                $display("FAIL clear_post cyc=%0d got en=%b d=%0d/%0d/%0d exp en=%b d=%0d/%0d/%0d", i,
                         en_judge, first_order_data, second_order_data, third_order_data, e_en, e_d1, e_d2, e_d3);
            end
            vectors++;
            if (en_judge) pulses++;
        end
        if (pulses != 1) begin
            miscompares++;
            $display("FAIL clear_pulses got %0d exp 1", pulses);
        end
        vectors++;
    endtask

    task automatic test_async_reset();
        step(0, 0, 1);
        for (int i = 0; i < 26; i++) begin
            step(1, $urandom_range(0, 4095), 0);
            if ({en_judge, first_order_data, second_order_data, third_order_data} !== m_exp) begin
                miscompares++;
                $display("FAIL areset_pre cyc=%0d got en=%b d=%0d/%0d/%0d exp en=%b d=%0d/%0d/%0d", i,
                         en_judge, first_order_data, second_order_data, third_order_data, e_en, e_d1, e_d2, e_d3);
            end
            vectors++;
        end
        sample_valid = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        if ({first_order_data, second_order_data, third_order_data} !== 39'd0) begin
            miscompares++;
            $display("FAIL areset_immediate got d=%0d/%0d/%0d exp d=0/0/0",
                     first_order_data, second_order_data, third_order_data);
        end
        vectors++;
        model_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(i < 16, $urandom_range(0, 4095), 0);
            if ({en_judge, first_order_data, second_order_data, third_order_data} !== m_exp) begin
                miscompares++;
                $display("FAIL areset_post cyc=%0d got en=%b d=%0d/%0d/%0d exp en=%b d=%0d/%0d/%0d", i,
                         en_judge, first_order_data, second_order_data, third_order_data, e_en, e_d1, e_d2, e_d3);
            end
            vectors++;
        end
    endtask

    task automatic test_random();
        bit v, c;
        for (int i = 0; i < 1500; i++) begin
            v = ($urandom_range(0, 9) < 7);
            c = ($urandom_range(0, 199) == 0);
            step(v, ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 4095)
                                                : $urandom_range(0, 4095), c);
            if ({en_judge, first_order_data, second_order_data, third_order_data} !== m_exp) begin
                miscompares++;
                $display("FAIL random cyc=%0d got en=%b d=%0d/%0d/%0d exp en=%b d=%0d/%0d/%0d", i,
                         en_judge, first_order_data, second_order_data, third_order_data, e_en, e_d1, e_d2, e_d3);
            end
            vectors++;
        end
    endtask

    task automatic test_back_to_back();
        step(0, 0, 1);
        for (int i = 0; i < 200; i++) begin
            step(1, $urandom_range(0, 4095), 0);
            if ({en_judge, first_order_data, second_order_data, third_order_data} !== m_exp) begin
                miscompares++;
                $display("FAIL back_to_back cyc=%0d got en=%b d=%0d/%0d/%0d exp en=%b d=%0d/%0d/%0d", i,
                         en_judge, first_order_data, second_order_data, third_order_data, e_en, e_d1, e_d2, e_d3);
            end
            vectors++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_constant();
        test_ramp();
        test_step();
        test_gapped();
        test_clear_mid();
        test_async_reset();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
